seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, registered ALU with a valid/ready handshake on input and output.
//  Supports AND, OR, ADD, MUL and DIV on WIDTH-bit unsigned operands.
//  MUL uses an iterative shift-add datapath and DIV uses an iterative restoring datapath.
//  Sits between an operand source and a result sink; either side may stall.
// PARAMETERS
//  WIDTH  8  operand width in bits, >= 2
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        op/a/b valid
//  in_ready   out  1        block can accept an operation
//  op         in   3        000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIV, others illegal
//  a          in   WIDTH    operand A (unsigned)
//  b          in   WIDTH    operand B (unsigned)
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        sink accepts result
//  result     out  2*WIDTH  see arithmetic rules below
//  div_zero   out  1        DIV with b==0; valid with out_valid
//  illegal    out  1        unsupported op; valid with out_valid
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, out_valid=0, result=0, div_zero=0, illegal=0.
//    in_ready=1 while in reset and after release. Any in-flight op is discarded.
//  - FSM states: IDLE, CALC, DONE.
//      IDLE: in_ready=1.
//          Accept when in_valid & in_ready; operands are latched at acceptance.
//          AND/OR/ADD, illegal op, DIV by 0 -> DONE.
//          MUL, or DIV with b!=0 -> CALC with iteration counter=0.
//      CALC: in_ready=0. One iteration per cycle. After WIDTH iterations -> DONE.
//      DONE: out_valid=1, in_ready=0. result and flags are stable until handshake.
//          out_valid & out_ready -> IDLE; out_valid drops next cycle.
//  - No accept in the same cycle as the output handshake; throughput is 1 op per 2+ cycles.
//  - Latency (accept edge to first out_valid cycle):
//      1 cycle for AND/OR/ADD/illegal/div-by-0.
//      WIDTH+1 cycles for MUL and DIV.
//  - Arithmetic: all unsigned; result bits not listed below are 0.
//      AND/OR: result[WIDTH-1:0] = a op b.
//      ADD: result[WIDTH:0] = a + b, carry in bit WIDTH.
//      MUL: result = a * b, full 2*WIDTH product, no truncation.
//      DIV: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
//      DIV b==0: quotient = all ones, remainder = a, div_zero=1.
//      Illegal op: result=0, illegal=1.
//  - Flags are cleared on the accept of the next op.
//  - in_valid while in_ready=0 is ignored; the source must hold its request.
//  - op/a/b changing during CALC has no effect.
//  - rst asserted during CALC or DONE: return to IDLE immediately; no out_valid for the aborted op.
// TESTING  (WIDTH=8 unless noted)
//  - AND 0xF0,0x3C -> out_valid 1 cycle after accept, result=0x0030.
//    OR 0xF0,0x0F -> result=0x00FF.
//  - ADD 0xFF,0x01 -> result=0x0100, carry set.
//    ADD 0x00,0x00 -> result=0x0000.
//  - MUL 0xFF,0xFF -> out_valid exactly 9 cycles after accept, result=0xFE01.
//    MUL 0x00,0x7F -> result=0x0000.
//  - DIV 200,7 -> result=0x041C (r=4, q=28), latency 9.
//    DIV 0x55,0x00 -> result=0x55FF, div_zero=1, latency 1.
//  - Backpressure: hold out_ready=0 for 5 cycles on MUL 3*5.
//    Required: result=0x000F stable, in_ready=0 throughout.
//    Then out_ready=1 -> IDLE next cycle; op=111 -> illegal=1, result=0.
//  - rst pulse mid-CALC of DIV -> outputs zero, in_ready=1, no stray out_valid.
//    WIDTH=2, DIV 3,1 -> result=4'b0011.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU (AND/OR/ADD/MUL/DIV) with valid/ready on both sides; MUL is shift-add, DIV is restoring.
// Latency 1 for single-cycle ops, WIDTH+1 for MUL/DIV; the result is held in DONE until the sink accepts it.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 go_calc;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   simple_res;
    logic                 simple_dz;
    logic                 simple_ill;

    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   prod, mcand, prod_n;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem, quo, rem_n, quo_n;
    logic [WIDTH:0]       trial;
    logic                 ge;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Single-cycle results, also covering illegal ops and divide by zero.
    always_comb begin
        simple_res = '0;
        simple_dz  = 1'b0;
        simple_ill = 1'b0;
        go_calc    = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
        case (op)
            OP_AND: simple_res[WIDTH-1:0] = a & b;
            OP_OR:  simple_res[WIDTH-1:0] = a | b;
            OP_ADD: simple_res[WIDTH:0]   = {1'b0, a} + {1'b0, b};
            OP_MUL: simple_res            = '0;
            OP_DIV: begin
                simple_res = {a, {WIDTH{1'b1}}};
                simple_dz  = 1'b1;
            end
            default: simple_ill = 1'b1;
        endcase
    end

    // Both iterative datapaths step every CALC cycle; is_div selects which one lands in result.
    always_comb begin
        trial  = {rem, quo[WIDTH-1]};
        ge     = (trial >= {1'b0, b_r});
        rem_n  = ge ? (trial[WIDTH-1:0] - b_r) : trial[WIDTH-1:0];
        quo_n  = {quo[WIDTH-2:0], ge};
        prod_n = mplier[0] ? (prod + mcand) : prod;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = go_calc ? CALC : DONE;
            CALC: if (last_iter) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            b_r      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    result   <= go_calc ? '0 : simple_res;
                    div_zero <= go_calc ? 1'b0 : simple_dz;
                    illegal  <= go_calc ? 1'b0 : simple_ill;
                    cnt      <= '0;
                    is_div   <= (op == OP_DIV);
                    b_r      <= b;
                    prod     <= '0;
                    mcand    <= {{WIDTH{1'b0}}, a};
                    mplier   <= b;
                    rem      <= '0;
                    quo      <= a;
                end
                CALC: begin
                    cnt    <= cnt + CW'(1);
                    prod   <= prod_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= rem_n;
                    quo    <= quo_n;
                    if (last_iter)
                        result <= is_div ? {rem_n, quo_n} : prod_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic model + scoreboard checked every output-valid cycle, plus literal pins.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, div_zero, illegal;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] result;

    logic        v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_div_zero, v2_illegal;
    logic [2:0]  v2_op;
    logic [1:0]  v2_a, v2_b;
    logic [3:0]  v2_result;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_zero(div_zero), .illegal(illegal)
    );

    seq_alu #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2_in_valid), .in_ready(v2_in_ready), .op(v2_op),
        .a(v2_a), .b(v2_b), .out_valid(v2_out_valid), .out_ready(v2_out_ready),
        .result(v2_result), .div_zero(v2_div_zero), .illegal(v2_illegal)
    );

    typedef struct {
        logic [15:0] res;
        logic        dz;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, cur_lat = 0;
    bit          pend = 0, seen = 0;
    logic [15:0] last_res = '0;
    logic        last_dz = 1'b0, last_ill = 1'b0;
    int          last_lat = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // What the result must be, straight from the arithmetic rules.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input int acc);
        exp_t e;
        int ix, iy;
        ix = x; iy = y;
        e.res = '0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = acc;
        case (o)
            3'd0: e.res = 16'(ix & iy);
            3'd1: e.res = 16'(ix | iy);
            3'd2: e.res = 16'(ix + iy);
            3'd3: begin e.res = 16'(ix * iy); e.lat = 9; end
            3'd4: begin
                if (iy == 0) begin
                    e.res = {x, 8'hFF};
                    e.dz  = 1'b1;
                end else begin
                    e.res = 16'((ix % iy) * 256 + ix / iy);
                    e.lat = 9;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Latency counts edges from the accept edge to the edge that first samples out_valid high.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            pend = 0;
            seen = 0;
        end else begin
            if (pend && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                last_lat = cur_lat;
                done_cnt++;
                seen = 0;
            end
            pend = out_valid;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stray_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        cur_lat = cyc - q[0].acc + 1;
                        chk("latency", cur_lat, q[0].lat);
                        seen = 1;
                    end
                    chk("result", result, q[0].res);
                    chk("div_zero", div_zero, q[0].dz);
                    chk("illegal", illegal, q[0].ill);
                    chk("in_ready_busy", in_ready, 0);
                    last_res = result;
                    last_dz  = div_zero;
                    last_ill = illegal;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        bit ok;
        ok = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                q.push_back(model(o, x, y, cyc + 1));
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        for (int i = 0; i < 60; i++) begin
            if (done_cnt != start) break;
            @(negedge clk);
        end
        chk("done_seen", done_cnt != start, 1);
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] er, input int el);
        int start;
        start = done_cnt;
        issue(o, x, y);
        wait_done(start);
        chk({nm, "_res"}, last_res, er);
        chk({nm, "_lat"}, last_lat, el);
    endtask

    initial begin
        int start, n;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        v2_in_valid = 1'b0; v2_op = '0; v2_a = '0; v2_b = '0; v2_out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {div_zero, illegal}, 0);
        chk("rst_v2_in_ready", v2_in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run("and",       3'd0, 8'hF0, 8'h3C, 16'h0030, 1);
        run("or",        3'd1, 8'hF0, 8'h0F, 16'h00FF, 1);
        run("add_carry", 3'd2, 8'hFF, 8'h01, 16'h0100, 1);
        run("add_zero",  3'd2, 8'h00, 8'h00, 16'h0000, 1);
        run("mul_max",   3'd3, 8'hFF, 8'hFF, 16'hFE01, 9);
        run("mul_zero",  3'd3, 8'h00, 8'h7F, 16'h0000, 9);
        run("div",       3'd4, 8'd200, 8'd7, 16'h041C, 9);
        run("div_by0",   3'd4, 8'h55, 8'h00, 16'h55FF, 1);
        chk("div_by0_flag", last_dz, 1);

        // Sink stalls; a competing request must be ignored while busy.
        @(negedge clk);
        out_ready = 1'b0;
        start = done_cnt;
        issue(3'd3, 8'd3, 8'd5);
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'd2; a = 8'd1; b = 8'd1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 16'h000F);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_done", done_cnt - start, 1);
        chk("bp_last_res", last_res, 16'h000F);

        run("illegal", 3'd7, 8'hAA, 8'h55, 16'h0000, 1);
        chk("illegal_flag", last_ill, 1);
        run("and_clear", 3'd0, 8'h01, 8'h01, 16'h0001, 1);
        chk("flags_cleared", {last_dz, last_ill}, 0);

        // Abort a division mid-iteration.
        start = done_cnt;
        issue(3'd4, 8'd200, 8'd7);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_result", done_cnt - start, 0);

        // WIDTH=2 instance: DIV 3,1.
        @(negedge clk);
        v2_in_valid = 1'b1; v2_op = 3'd4; v2_a = 2'd3; v2_b = 2'd1;
        chk("v2_in_ready", v2_in_ready, 1);
        @(negedge clk);
        v2_in_valid = 1'b0;
        n = 1;
        while (!v2_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("v2_latency", n, 3);
        chk("v2_result", v2_result, 4'b0011);
        chk("v2_flags", {v2_div_zero, v2_illegal}, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
